lc3_regfile_sb: RTL
===================

Name: lc3_regfile_sb

Overview:
- Parametrised general-purpose register file for the multi-cycle / pipelined LC-3 datapath.
- Provides two combinational read ports, one write-back port with same-cycle write-to-read bypass, and a per-register busy scoreboard.
- The issue stage uses the scoreboard to stall on RAW/WAW hazards.
- Also owns the NZP condition-code register, updated on every write-back.

Parameters:
- WIDTH, 16, data width of each register.
- NUM_REGS, 8, number of registers (power of two, >= 2).
- AW, $clog2(NUM_REGS), register address width (derived; do not override).
- BYPASS, 1, 1 = write-back data forwarded to read ports in the same cycle; 0 = reads return the stored value only.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous active-low reset (0 = reset).
- rd_addr_a  in  AW  read port A address (SR1).
- rd_addr_b  in  AW  read port B address (SR2).
- rd_data_a  out  WIDTH  read port A data.
- rd_data_b  out  WIDTH  read port B data.
- rd_busy_a  out  1  register at rd_addr_a has a pending write.
- rd_busy_b  out  1  register at rd_addr_b has a pending write.
- issue_valid  in  1  instruction requests to claim a destination register.
- issue_dst  in  AW  destination register being claimed.
- issue_ready  out  1  claim accepted this cycle.
- wb_valid  in  1  write-back strobe.
- wb_addr  in  AW  write-back register.
- wb_data  in  WIDTH  write-back data.
- nzp  out  3  condition codes {N,Z,P}.
- wb_unexpected  out  1  sticky error: write-back to a register that was not busy.

Behaviour:
- Reset (Reset==0 at a clock edge): all registers = 0, all busy bits = 0, nzp = 3'b010, wb_unexpected = 0. Reset overrides any concurrent issue or write-back; pending claims are discarded.
- Reads are combinational, with zero latency.
- Bypass (BYPASS=1): if wb_valid and wb_addr == rd_addr_x, then rd_data_x = wb_data and rd_busy_x = 0. Otherwise rd_data_x = stored value and rd_busy_x = busy[rd_addr_x].
- With BYPASS=0, rd_busy_x = busy[rd_addr_x] regardless of wb.
- Write: on a clock edge with wb_valid, reg[wb_addr] <= wb_data.
- NZP update on the same edge as the write:
  - N = wb_data[WIDTH-1].
  - Z = (wb_data == 0).
  - P = !N && !Z.
  - Exactly one bit of nzp is set at all times.
- issue_ready = issue_valid && (!busy[issue_dst] || (wb_valid && wb_addr == issue_dst)). The second term lets a claim proceed when the pending write retires in the same cycle (WAW resolution). The signal is combinational, with no dependence on rd_*.
- Busy update per register r at each edge, in priority order:
  - set if issue_ready && issue_dst == r;
  - else clear if wb_valid && wb_addr == r;
  - else hold.
- Simultaneous issue and write-back to the same register: the data is written, NZP is updated, and busy ends at 1 (the new claim is outstanding).
- Write-back to a non-busy register: the write still occurs, NZP is updated, and wb_unexpected is set and held until reset. No write-back is ever dropped.
- Issue with issue_valid=0: no state change, issue_ready=0.
- Address widths: all addresses are exactly AW bits, so no out-of-range case exists.

Decomposition:
- Package lc3_rf_pkg:
  - NZP encodings NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, and NZP_RESET=NZP_Z;
  - function calc_nzp(WIDTH-generic via parameterised class or fixed 16 with sign-bit argument).
- Sub-module rf_scoreboard(NUM_REGS, AW):
  - holds the busy vector;
  - computes issue_ready and the busy set/clear logic;
  - drives wb_unexpected.
- The top level holds the storage array, the read/bypass muxes and the NZP register.

Test Plan:
- Reset then read all 8 registers -> rd_data_a/b = 16'h0000, rd_busy = 0, nzp = 3'b010, issue_ready = 1 for any dst.
- Issue dst=3, next cycle issue dst=3 again -> second issue_ready = 0. Then wb_valid addr=3 data=16'h8001 -> reg3 = 8001, nzp = 3'b100, busy[3] cleared.
- BYPASS=1: wb addr=5 data=16'h1234 while rd_addr_a=5 -> rd_data_a = 1234 and rd_busy_a = 0 in the same cycle. Repeat with BYPASS=0 -> old value returned and busy shown.
- Issue dst=2 and wb addr=2 data=0 in the same cycle, with reg2 previously busy -> issue_ready = 1, reg2 = 0, nzp = 3'b010, busy[2] = 1 afterwards.
- wb addr=6 data=16'h0007 with reg6 not busy -> reg6 = 7, nzp = 3'b001, wb_unexpected = 1 and held. Assert Reset=0 for one cycle -> wb_unexpected = 0.
- Claim regs 1, 4 and 7, then assert Reset=0 mid-flight together with wb_valid addr=4 -> after reset all busy = 0, reg4 = 0, nzp = 3'b010.
- NUM_REGS=16, WIDTH=32: write 32'hFFFF_FFFF to r15 -> read back, nzp = 3'b100.

Source files
------------

// File: rtl/lc3_regfile_sb_pkg.sv
// Shared condition-code encodings and the NZP derivation used on every write-back.
// Pure declarations; no clocked logic lives here.
package lc3_rf_pkg;

    localparam logic [2:0] NZP_N     = 3'b100;
    localparam logic [2:0] NZP_Z     = 3'b010;
    localparam logic [2:0] NZP_P     = 3'b001;
    localparam logic [2:0] NZP_RESET = NZP_Z;

    // Width-independent: the caller supplies the sign bit and the all-zero flag.
    function automatic logic [2:0] calc_nzp(input logic sign, input logic zero);
        if (zero) begin
            return NZP_Z;
        end else if (sign) begin
            return NZP_N;
        end
        return NZP_P;
    endfunction

endpackage

// File: rtl/lc3_regfile_sb_scoreboard.sv
// Per-register busy scoreboard: issue_ready is combinational, busy updates on the next edge.
// A claim stalls while its destination is busy unless that register retires in the same cycle.
module rf_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_dst,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    output logic                issue_ready,
    output logic [NUM_REGS-1:0] busy,
    output logic                wb_unexpected
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                unexp_q, unexp_d;

    always_comb begin
        issue_ready = issue_valid &&
                      (!busy_q[issue_dst] || (wb_valid && (wb_addr == issue_dst)));
        busy_d  = busy_q;
        unexp_d = unexp_q;
        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
            if (!busy_q[wb_addr]) begin
                unexp_d = 1'b1;
            end
        end
        // Applied after the clear so a same-cycle claim leaves the register busy.
        if (issue_ready) begin
            busy_d[issue_dst] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            busy_q  <= '0;
            unexp_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            unexp_q <= unexp_d;
        end
    end

    assign busy          = busy_q;
    assign wb_unexpected = unexp_q;

endmodule

// File: rtl/lc3_regfile_sb.sv
// LC-3 register file: two zero-latency read ports with optional write-back bypass, NZP register.
// Write-back is never stalled; issue claims are gated by the scoreboard's issue_ready.
module lc3_regfile_sb
    import lc3_rf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_busy_a,
    output logic             rd_busy_b,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dst,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic [2:0]       nzp,
    output logic             wb_unexpected
);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [WIDTH-1:0]    regs_d [NUM_REGS];
    logic [2:0]          nzp_q, nzp_d;
    logic [NUM_REGS-1:0] busy;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_sb (
        .Clk           (Clk),
        .Reset         (Reset),
        .issue_valid   (issue_valid),
        .issue_dst     (issue_dst),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .issue_ready   (issue_ready),
        .busy          (busy),
        .wb_unexpected (wb_unexpected)
    );

    always_comb begin
        regs_d = regs_q;
        nzp_d  = nzp_q;
        if (wb_valid) begin
            regs_d[wb_addr] = wb_data;
            nzp_d           = calc_nzp(wb_data[WIDTH-1], wb_data == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= NZP_RESET;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
        end
    end

    // A forwarded operand is by definition no longer pending.
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_busy_a = busy[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        rd_busy_b = busy[rd_addr_b];
        if ((BYPASS != 0) && wb_valid && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
            rd_busy_a = 1'b0;
        end
        if ((BYPASS != 0) && wb_valid && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
            rd_busy_b = 1'b0;
        end
    end

    assign nzp = nzp_q;

endmodule
